seq_detector_moore_param: RTL and testbench

//  Parametrised Moore sequence detector: serial bit stream against a runtime-loadable PAT_W-bit pattern.

---
 rtl/seq_det_pkg.sv | 10 +
 rtl/sat_counter.sv | 37 +++
 rtl/seq_detector_moore_param.sv | 115 +++++++++++
 tb/tb_seq_detector_moore_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the parametrised Moore sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_HUNT   = 2'd1,
    S_DETECT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; clear plus increment in one cycle yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = inc ? W'(1) : '0;
    else if (inc && (count_q != '1))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= (count_d == '1);
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_moore_param.sv
// Moore detector of a runtime-loadable PAT_W-bit pattern in a valid-qualified
// serial stream, with overlap/non-overlap modes and a saturating match counter.
module seq_detector_moore_param #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(4'b1011),
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             dout_moore,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  import seq_det_pkg::*;

  localparam int             FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] hist_sh;
  logic [FW-1:0]    fill_inc;
  logic             sh_match;

  // Oldest bit falls off the top; the cast keeps the low PAT_W bits.
  assign hist_sh  = PAT_W'({hist_q, din});
  assign fill_inc = fill_q + FW'(1);
  assign sh_match = (hist_sh == pat_q);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    if (pat_load) begin
      pat_d   = pattern_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else begin
      unique case (state_q)
        S_FILL: if (din_valid) begin
          hist_d = hist_sh;
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL)
            state_d = sh_match ? S_DETECT : S_HUNT;
        end
        S_HUNT: if (din_valid) begin
          hist_d  = hist_sh;
          state_d = sh_match ? S_DETECT : S_HUNT;
        end
        S_DETECT: begin
          if (!din_valid) begin
            if (overlap_en) begin
              state_d = S_HUNT;
            end else begin
              state_d = S_FILL;
              hist_d  = '0;
              fill_d  = '0;
            end
          end else if (overlap_en) begin
            hist_d  = hist_sh;
            state_d = sh_match ? S_DETECT : S_HUNT;
          end else begin
            // Non-overlap restarts the window with this bit as its first.
            hist_d  = PAT_W'(din);
            fill_d  = FW'(1);
            state_d = ((PAT_W == 1) && (din == pat_q[0])) ? S_DETECT : S_FILL;
          end
        end
        default: begin
          state_d = S_FILL;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RESET;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
    end
  end

  assign dout_moore = (state_q == S_DETECT);

  // S_DETECT never holds without a fresh match, so any next-state of
  // S_DETECT is an entry, back-to-back re-entries included.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (state_d == S_DETECT),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Bench: vector table, hand-written corner sequences and random stream vs a queue-based model.
module tb_seq_detector_moore_param;

  logic       clk = 1'b0;
  logic       rstn, din_valid, din, pat_load, overlap_en, cnt_clr;
  logic [3:0] pattern_in;
  logic       dout, dout2, sat, sat2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detector_moore_param #(.PAT_W(4), .PAT_RESET(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pattern_in(pattern_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .dout_moore(dout), .match_count(cnt), .count_sat(sat));

  seq_detector_moore_param #(.PAT_W(4), .PAT_RESET(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pattern_in(pattern_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .dout_moore(dout2), .match_count(cnt2), .count_sat(sat2));

  int checks = 0, failures = 0;

  // Reference model: the accepted bits since the window was last cleared.
  bit         mq[$];
  logic [3:0] m_pat;
  bit         m_det;
  int         m_cnt, m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clk();
    bit         hit;
    logic [3:0] win;
    hit = 1'b0;
    if (!rstn) begin
      mq.delete(); m_pat = 4'b1011; m_det = 1'b0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    if (pat_load) begin
      m_pat = pattern_in;
      mq.delete();
    end else begin
      if (m_det && !overlap_en) mq.delete();
      if (din_valid) begin
        mq.push_back(din);
        if (mq.size() > 4) void'(mq.pop_front());
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) win[3-i] = mq[i];
          hit = (win == m_pat);
        end
      end
    end
    m_det  = hit;
    m_cnt  = cnt_clr ? int'(hit) : ((hit && m_cnt  < 255) ? m_cnt  + 1 : m_cnt);
    m_cnt2 = cnt_clr ? int'(hit) : ((hit && m_cnt2 < 3)   ? m_cnt2 + 1 : m_cnt2);
  endtask

  task automatic step(input bit v, input bit d, input bit ld = 1'b0,
                      input logic [3:0] p = 4'h0, input bit ov = 1'b1, input bit clr = 1'b0);
    @(negedge clk);
    din_valid = v; din = d; pat_load = ld; pattern_in = p; overlap_en = ov; cnt_clr = clr;
    @(posedge clk);
    model_clk();
    #1;
    chk("model_dout",  dout,  m_det);
    chk("model_dout2", dout2, m_det);
    chk("model_cnt",   cnt,   m_cnt);
    chk("model_sat",   sat,   m_cnt == 255);
    chk("model_cnt2",  cnt2,  m_cnt2);
    chk("model_sat2",  sat2,  m_cnt2 == 3);
  endtask

  // Load a pattern and clear the counter in one idle cycle.
  task automatic fresh(input logic [3:0] p, input bit ov);
    step(1'b0, 1'b0, 1'b1, p, ov, 1'b1);
  endtask

  typedef struct {
    bit v, d, ld; logic [3:0] p; bit ov, clr; bit e_dout; logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input bit d, input bit ld, input logic [3:0] p,
                     input bit ov, input bit clr, input bit ed, input logic [7:0] ec);
    vec_t r;
    r.v = v; r.d = d; r.ld = ld; r.p = p; r.ov = ov; r.clr = clr; r.e_dout = ed; r.e_cnt = ec;
    tbl.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    din_valid = 0; din = 0; pat_load = 0; pattern_in = 0; overlap_en = 1; cnt_clr = 0;
    rstn = 1'b0;
    step(0, 0); step(0, 0);
    rstn = 1'b1;
    chk("rst_dout", dout, 1'b0);
    chk("rst_cnt",  cnt,  8'd0);
    chk("rst_sat",  sat,  1'b0);

    // Reset pattern 1011, overlapping: pulses after bits 4 and 7.
    add(1,1,0,0,1,0, 0,0); add(1,0,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0);
    add(1,1,0,0,1,0, 1,1); add(1,0,0,0,1,0, 0,1); add(1,1,0,0,1,0, 0,1);
    add(1,1,0,0,1,0, 1,2);
    // 1111 overlapping: back-to-back pulses after bits 4..7.
    add(0,0,1,4'hF,1,1, 0,0);
    for (int i = 1; i <= 7; i++) add(1,1,0,0,1,0, i >= 4, (i >= 4) ? 8'(i-3) : 8'd0);
    // 1111 non-overlapping: pulse after bit 4, next after bit 8.
    add(0,0,1,4'hF,0,1, 0,0);
    for (int i = 1; i <= 8; i++) add(1,1,0,0,0,0, (i == 4) || (i == 8),
                                     (i == 8) ? 8'd2 : ((i >= 4) ? 8'd1 : 8'd0));
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].ld, tbl[i].p, tbl[i].ov, tbl[i].clr);
      chk("tbl_dout", dout, tbl[i].e_dout);
      chk("tbl_cnt",  cnt,  tbl[i].e_cnt);
    end

    // Valid gap: history holds, pulse one cycle after the completing bit.
    fresh(4'b1011, 1);
    step(1,1); step(1,0); step(1,1);
    for (int i = 0; i < 5; i++) begin step(0,1); chk("gap_dout", dout, 1'b0); end
    step(1,1); chk("gap_pulse", dout, 1'b1); chk("gap_cnt", cnt, 8'd1);
    step(0,0); chk("gap_after", dout, 1'b0);

    // pat_load drops the coincident bit and restarts the window.
    fresh(4'b1011, 1);
    step(1,1); step(1,0); step(1,1); step(1,1); chk("ld_pre_cnt", cnt, 8'd1);
    step(1,1); step(1,0); step(1,1);
    step(1,1,1,4'b0000); chk("ld_dout", dout, 1'b0); chk("ld_cnt", cnt, 8'd1);
    step(1,0); step(1,0); step(1,0); chk("ld_fill3", dout, 1'b0);
    step(1,0); chk("ld_pulse", dout, 1'b1); chk("ld_cnt2", cnt, 8'd2);
    // Load while a detect is pending keeps the count taken on entry.
    step(1,0,1,4'b1011); chk("ld_det_dout", dout, 1'b0); chk("ld_det_cnt", cnt, 8'd2);

    // Narrow counter saturates; clear coincident with a match gives 1.
    fresh(4'hF, 1);
    step(1,1); step(1,1); step(1,1);
    step(1,1); chk("sat_c1", cnt2, 2'd1); chk("sat_s1", sat2, 1'b0);
    step(1,1); chk("sat_c2", cnt2, 2'd2); chk("sat_s2", sat2, 1'b0);
    step(1,1); chk("sat_c3", cnt2, 2'd3); chk("sat_s3", sat2, 1'b1);
    step(1,1); chk("sat_c4", cnt2, 2'd3); chk("sat_s4", sat2, 1'b1);
    step(1,1,0,0,1,1); chk("clr_inc_c", cnt2, 2'd1); chk("clr_inc_s", sat2, 1'b0);
    chk("clr_inc_c8", cnt, 8'd1);
    step(0,0,0,0,1,1); chk("clr_only", cnt, 8'd0);

    // Random stream against the model.
    begin
      bit ov = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) ov = ~ov;
        step($urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 39) == 0, 4'($urandom), ov,
             $urandom_range(0, 59) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
